// File: rtl/mmio_bridge_pkg.sv
// Shared types and byte constants for the UART-to-MMIO bridge master.
package mmio_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_BUS,
        ST_RESP
    } state_t;

    localparam logic [7:0] OP_WR   = 8'h57;  // 'W'
    localparam logic [7:0] OP_RD   = 8'h52;  // 'R'
    localparam logic [7:0] RSP_ACK = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_ERR = 8'h3F;  // '?'
    localparam logic [7:0] RSP_TMO = 8'h54;  // 'T'

    localparam int unsigned ADDR_BYTES = 3;
    localparam int unsigned DATA_BYTES = 4;

endpackage

// File: rtl/mmio_uart_bridge_master.sv
// Byte-stream to single-cycle FPro MMIO initiator; responses returned as bytes.
// Optional inter-byte frame timeout enabled by defining MMIO_BRIDGE_TIMEOUT_EN.
module mmio_uart_bridge_master
`ifdef MMIO_BRIDGE_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        mmio_cs,
    output logic        mmio_wr,
    output logic        mmio_rd,
    output logic [20:0] mmio_addr,
    output logic [31:0] mmio_wr_data,
    input  logic [31:0] mmio_rd_data,
    output logic        busy
);
    import mmio_bridge_pkg::*;

    localparam logic [1:0] ADDR_LAST = 2'(ADDR_BYTES - 1);
    localparam logic [1:0] DATA_LAST = 2'(DATA_BYTES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_cnt;
    logic        r_is_wr;
    logic [20:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [1:0]  r_tx_cnt;
    logic        w_rx_fire;
    logic        w_tx_fire;
    logic        w_in_frame;
    logic        w_tmo_hit;

    assign w_rx_fire  = rx_valid & rx_ready;
    assign w_tx_fire  = tx_valid & tx_ready;
    assign w_in_frame = (r_state == ST_ADDR) || (r_state == ST_DATA);

`ifdef MMIO_BRIDGE_TIMEOUT_EN
    localparam int unsigned TMO_W = ($clog2(TIMEOUT_CYCLES) > 20) ? $clog2(TIMEOUT_CYCLES) : 20;
    logic [TMO_W-1:0] r_tmo;

    // Counter holds the number of idle cycles seen since the last accepted byte.
    always_ff @(posedge clk) begin
        if (reset || !w_in_frame || rx_valid) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    assign w_tmo_hit = w_in_frame && !rx_valid && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        rx_ready = 1'b0;
        tx_valid = 1'b0;
        mmio_cs  = 1'b0;
        mmio_wr  = 1'b0;
        mmio_rd  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    w_next = (rx_data == OP_WR || rx_data == OP_RD) ? ST_ADDR : ST_RESP;
                end
            end
            ST_ADDR: begin
                rx_ready = 1'b1;
                if (w_tmo_hit) begin
                    w_next = ST_RESP;
                end else if (rx_valid && r_cnt == '0) begin
                    w_next = r_is_wr ? ST_DATA : ST_BUS;
                end
            end
            ST_DATA: begin
                rx_ready = 1'b1;
                if (w_tmo_hit) begin
                    w_next = ST_RESP;
                end else if (rx_valid && r_cnt == '0) begin
                    w_next = ST_BUS;
                end
            end
            ST_BUS: begin
                mmio_cs = 1'b1;
                mmio_wr = r_is_wr;
                mmio_rd = !r_is_wr;
                w_next  = ST_RESP;
            end
            ST_RESP: begin
                tx_valid = 1'b1;
                if (tx_ready && r_tx_cnt == '0) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // r_rdata doubles as the response shift register: top byte is always tx_data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_is_wr  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_tx_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rx_fire) begin
                        r_is_wr <= (rx_data == OP_WR);
                        r_cnt   <= ADDR_LAST;
                        if (rx_data != OP_WR && rx_data != OP_RD) begin
                            r_rdata  <= {RSP_ERR, 24'h000000};
                            r_tx_cnt <= '0;
                        end
                    end
                end
                ST_ADDR: begin
                    if (w_tmo_hit) begin
                        r_rdata  <= {RSP_TMO, 24'h000000};
                        r_tx_cnt <= '0;
                    end else if (w_rx_fire) begin
                        r_addr <= {r_addr[12:0], rx_data};
                        r_cnt  <= (r_cnt == '0) ? DATA_LAST : r_cnt - 2'd1;
                    end
                end
                ST_DATA: begin
                    if (w_tmo_hit) begin
                        r_rdata  <= {RSP_TMO, 24'h000000};
                        r_tx_cnt <= '0;
                    end else if (w_rx_fire) begin
                        r_wdata <= {r_wdata[23:0], rx_data};
                        r_cnt   <= (r_cnt == '0) ? '0 : r_cnt - 2'd1;
                    end
                end
                ST_BUS: begin
                    if (r_is_wr) begin
                        r_rdata  <= {RSP_ACK, 24'h000000};
                        r_tx_cnt <= '0;
                    end else begin
                        r_rdata  <= mmio_rd_data;
                        r_tx_cnt <= 2'd3;
                    end
                end
                ST_RESP: begin
                    if (w_tx_fire) begin
                        r_rdata  <= {r_rdata[23:0], 8'h00};
                        r_tx_cnt <= r_tx_cnt - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_data      = (r_state == ST_RESP) ? r_rdata[31:24] : '0;
    assign mmio_addr    = r_addr;
    assign mmio_wr_data = r_wdata;
    assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mmio_uart_bridge_master.sv
// Directed bench for mmio_uart_bridge_master; honours MMIO_BRIDGE_TIMEOUT_EN.
module tb_mmio_uart_bridge_master;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        mmio_cs;
    logic        mmio_wr;
    logic        mmio_rd;
    logic [20:0] mmio_addr;
    logic [31:0] mmio_wr_data;
    logic [31:0] mmio_rd_data;
    logic        busy;

    int n_cmp = 0;
    int n_fail = 0;
    int n_strobe = 0;
    int n_bad = 0;
    logic prev_cs = 1'b0;

    always #5 clk = ~clk;

`ifdef MMIO_BRIDGE_TIMEOUT_EN
    mmio_uart_bridge_master #(.TIMEOUT_CYCLES(100)) dut (
`else
    mmio_uart_bridge_master dut (
`endif
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
        .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data),
        .mmio_rd_data(mmio_rd_data), .busy(busy)
    );

    // Slot model: read data only presented while the read strobe is up.
    always_comb begin
        mmio_rd_data = 32'h0;
        if (mmio_rd) begin
            if (mmio_addr == 21'h000060)      mmio_rd_data = 32'hDEADBEEF;
            else if (mmio_addr == 21'h000001) mmio_rd_data = 32'h0BADF00D;
            else                              mmio_rd_data = 32'h01020304;
        end
    end

    // Strobe monitor: counts bus cycles and flags illegal strobe combinations.
    always @(posedge clk) begin
        #1;
        if (mmio_cs) begin
            n_strobe++;
            if (prev_cs) n_bad++;
            if (mmio_wr == mmio_rd) n_bad++;
        end else if (mmio_wr || mmio_rd) begin
            n_bad++;
        end
        prev_cs = mmio_cs;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("rx_accept", {31'b0, rx_ready}, 32'h1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic recv_byte(input string tag, input logic [7:0] exp);
        int w = 0;
        while (!tx_valid && w < 300) begin
            @(negedge clk);
            w++;
        end
        check(tag, {24'b0, tx_data}, {24'b0, exp});
        @(negedge clk);
    endtask

    initial begin
        int dev;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_rx_ready", {31'b0, rx_ready}, 32'h1);
        check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("rst_tx_data", {24'b0, tx_data}, 32'h0);
        check("rst_cs", {31'b0, mmio_cs}, 32'h0);
        check("rst_addr", {11'b0, mmio_addr}, 32'h0);
        check("rst_wdata", mmio_wr_data, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // 1: write frame, bus cycle right after last byte, ack one cycle later
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h80);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        check("t1_cs", {31'b0, mmio_cs}, 32'h1);
        check("t1_wr", {31'b0, mmio_wr}, 32'h1);
        check("t1_rd", {31'b0, mmio_rd}, 32'h0);
        check("t1_addr", {11'b0, mmio_addr}, 32'h000080);
        check("t1_wdata", mmio_wr_data, 32'h12345678);
        check("t1_rx_ready_bus", {31'b0, rx_ready}, 32'h0);
        check("t1_busy", {31'b0, busy}, 32'h1);
        @(negedge clk);
        check("t1_cs_after", {31'b0, mmio_cs}, 32'h0);
        check("t1_tx_valid", {31'b0, tx_valid}, 32'h1);
        check("t1_tx_data", {24'b0, tx_data}, 32'h4B);
        @(negedge clk);
        check("t1_tx_done", {31'b0, tx_valid}, 32'h0);
        check("t1_idle", {31'b0, busy}, 32'h0);
        check("t1_strobes", n_strobe, 1);

        // 2: read frame, four data bytes MSB first
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h60);
        check("t2_cs", {31'b0, mmio_cs}, 32'h1);
        check("t2_rd", {31'b0, mmio_rd}, 32'h1);
        check("t2_wr", {31'b0, mmio_wr}, 32'h0);
        check("t2_addr", {11'b0, mmio_addr}, 32'h000060);
        @(negedge clk);
        check("t2_tx_valid", {31'b0, tx_valid}, 32'h1);
        recv_byte("t2_b3", 8'hDE); recv_byte("t2_b2", 8'hAD);
        recv_byte("t2_b1", 8'hBE); recv_byte("t2_b0", 8'hEF);
        check("t2_tx_done", {31'b0, tx_valid}, 32'h0);
        check("t2_strobes", n_strobe, 2);

        // 3: unknown opcode, then a normal read
        send_byte(8'hAA);
        check("t3_no_cs", {31'b0, mmio_cs}, 32'h0);
        check("t3_tx_valid", {31'b0, tx_valid}, 32'h1);
        check("t3_err", {24'b0, tx_data}, 32'h3F);
        @(negedge clk);
        check("t3_tx_done", {31'b0, tx_valid}, 32'h0);
        check("t3_strobes_err", n_strobe, 2);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        check("t3_rd", {31'b0, mmio_rd}, 32'h1);
        check("t3_addr", {11'b0, mmio_addr}, 32'h000001);
        @(negedge clk);
        recv_byte("t3_b3", 8'h0B); recv_byte("t3_b2", 8'hAD);
        recv_byte("t3_b1", 8'hF0); recv_byte("t3_b0", 8'h0D);
        check("t3_strobes", n_strobe, 3);

        // 4: stalled response with the next frame's opcode already waiting
        tx_ready = 1'b0;
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h60);
        @(negedge clk);
        rx_data  = 8'h57;
        rx_valid = 1'b1;
        dev = 0;
        repeat (50) begin
            if (tx_valid !== 1'b1 || tx_data !== 8'hDE || rx_ready !== 1'b0) dev++;
            @(negedge clk);
        end
        check("t4_stall_stable", dev, 0);
        tx_ready = 1'b1;
        recv_byte("t4_b3", 8'hDE); recv_byte("t4_b2", 8'hAD);
        recv_byte("t4_b1", 8'hBE); recv_byte("t4_b0", 8'hEF);
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h01); send_byte(8'h23);
        send_byte(8'hA5); send_byte(8'hA5); send_byte(8'h5A); send_byte(8'h5A);
        check("t4_wr", {31'b0, mmio_wr}, 32'h1);
        check("t4_addr", {11'b0, mmio_addr}, 32'h000123);
        check("t4_wdata", mmio_wr_data, 32'hA5A55A5A);
        recv_byte("t4_ack", 8'h4B);
        check("t4_strobes", n_strobe, 5);

        // 5: reset mid-frame, then a frame with junk in A2[7:5]
        send_byte(8'h57); send_byte(8'h00);
        reset = 1'b1;
        @(negedge clk);
        check("t5_busy", {31'b0, busy}, 32'h0);
        check("t5_rx_ready", {31'b0, rx_ready}, 32'h1);
        check("t5_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("t5_tx_data", {24'b0, tx_data}, 32'h0);
        check("t5_addr", {11'b0, mmio_addr}, 32'h0);
        check("t5_wdata", mmio_wr_data, 32'h0);
        reset = 1'b0;
        send_byte(8'h57); send_byte(8'hE1); send_byte(8'h02); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        check("t5_wr", {31'b0, mmio_wr}, 32'h1);
        check("t5_addr_mask", {11'b0, mmio_addr}, 32'h010203);
        check("t5_wdata2", mmio_wr_data, 32'h11223344);
        recv_byte("t5_ack", 8'h4B);
        check("t5_strobes", n_strobe, 6);

        // 6: partial frame followed by silence
        send_byte(8'h57); send_byte(8'h00);
        dev = 0;
`ifdef MMIO_BRIDGE_TIMEOUT_EN
        repeat (99) begin
            @(negedge clk);
            if (tx_valid !== 1'b0) dev++;
        end
        check("t6_no_early_tmo", dev, 0);
        @(negedge clk);
        check("t6_tmo_valid", {31'b0, tx_valid}, 32'h1);
        check("t6_tmo_data", {24'b0, tx_data}, 32'h54);
        @(negedge clk);
        check("t6_idle", {31'b0, busy}, 32'h0);
`else
        repeat (200) begin
            @(negedge clk);
            if (busy !== 1'b1 || tx_valid !== 1'b0) dev++;
        end
        check("t6_waits", dev, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_reset_escape", {31'b0, busy}, 32'h0);
`endif
        check("t6_strobes", n_strobe, 6);
        check("strobe_rules", n_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
